hack_cpu_sequencer: RTL and testbench

- Multi-cycle control and datapath stage for the Hack-style CPU.
- Fetches 16-bit instructions and holds the A, D and PC registers.
- Drives the extended ALU's x, y and 9-bit instruction inputs, then consumes its out, zr and ng results.
- Performs register and memory writeback and jump resolution.
- Sits between the instruction/data memory interfaces and the extended ALU.

---
 rtl/hack_cpu_sequencer.sv | 114 +++++++++++
 tb/tb_hack_cpu_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_cpu_sequencer.sv
// hack_cpu_sequencer: multi-cycle Hack CPU control/datapath around an external extended ALU.
// Optional HALT_LOOP_EN adds a HALTED state that traps the canonical "@L; 0;JMP" self-loop.
module hack_cpu_sequencer #(
  parameter logic [14:0] RESET_PC = 15'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        instr_req,
  output logic [14:0] instr_addr,
  input  logic [15:0] instr_data,
  input  logic        instr_ack,
  output logic        data_req,
  output logic        data_we,
  output logic [14:0] data_addr,
  output logic [15:0] data_wdata,
  input  logic [15:0] data_rdata,
  input  logic        data_ack,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic [8:0]  alu_instr,
  input  logic [15:0] alu_out,
  input  logic        alu_zr,
  input  logic        alu_ng,
  output logic        halted
);
  typedef enum logic [2:0] {
    START, FETCH, DECODE, READ, EXEC, WRITE
`ifdef HALT_LOOP_EN
    , HALTED
`endif
  } state_t;
  state_t st;
  logic [15:0] a, d, ir, m, res;
  logic [14:0] pc, wa;
  logic taken;
  assign instr_req  = st == FETCH;
  assign instr_addr = pc;
  assign data_req   = st == READ || st == WRITE;
  assign data_we    = st == WRITE;
  assign data_addr  = st == WRITE ? wa : a[14:0];
  assign data_wdata = res;
  assign alu_x      = d;
  assign alu_y      = ir[12] ? m : a;
  assign alu_instr  = (st == READ || st == EXEC) ? {ir[14], ir[13], 1'b0, ir[11:6]} : 9'h000;
  assign taken      = (ir[2] & alu_ng) | (ir[1] & alu_zr) | (ir[0] & ~alu_ng & ~alu_zr);
`ifdef HALT_LOOP_EN
  logic prev_a, hp, trig;
  assign trig   = ir[2:0] == 3'b111 && prev_a && a[14:0] == pc - 15'd1;
  assign halted = st == HALTED;
`else
  assign halted = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      st  <= START;
      pc  <= RESET_PC;
      a   <= '0;
      d   <= '0;
      ir  <= '0;
      m   <= '0;
      res <= '0;
      wa  <= '0;
`ifdef HALT_LOOP_EN
      prev_a <= 1'b0;
      hp     <= 1'b0;
`endif
    end else begin
      case (st)
        START: st <= FETCH;
        FETCH: if (instr_ack) begin
          ir <= instr_data;
          st <= DECODE;
        end
        DECODE: if (!ir[15]) begin
          a  <= {1'b0, ir[14:0]};
          pc <= pc + 15'd1;
          st <= FETCH;
`ifdef HALT_LOOP_EN
          prev_a <= 1'b1;
`endif
        end else st <= ir[12] ? READ : EXEC;
        READ: if (data_ack) begin
          m  <= data_rdata;
          st <= EXEC;
        end
        EXEC: begin
          if (ir[5]) a <= alu_out;
          if (ir[4]) d <= alu_out;
          res <= alu_out;
          wa  <= a[14:0];
          pc  <= taken ? a[14:0] : pc + 15'd1;
`ifdef HALT_LOOP_EN
          prev_a <= 1'b0;
          hp     <= trig;
          st     <= ir[3] ? WRITE : trig ? HALTED : FETCH;
`else
          st <= ir[3] ? WRITE : FETCH;
`endif
        end
        WRITE: if (data_ack) begin
`ifdef HALT_LOOP_EN
          st <= hp ? HALTED : FETCH;
`else
          st <= FETCH;
`endif
        end
`ifdef HALT_LOOP_EN
        HALTED: st <= HALTED;
`endif
        default: st <= START;
      endcase
    end
  end
endmodule

// File: tb/tb_hack_cpu_sequencer.sv
// tb_hack_cpu_sequencer: scoreboard bench with ROM/RAM responders and a behavioural extended ALU.
module tb_hack_cpu_sequencer;
  logic clk = 0, reset = 1;
  logic instr_req, data_req, data_we, halted;
  logic [14:0] instr_addr, data_addr;
  logic [15:0] instr_data = 0, data_wdata, data_rdata = 0, alu_x, alu_y, alu_out;
  logic instr_ack = 0, data_ack = 0, alu_zr, alu_ng;
  logic [8:0] alu_instr;
  hack_cpu_sequencer dut (
    .clk(clk), .reset(reset),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_data(instr_data), .instr_ack(instr_ack),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_ack(data_ack),
    .alu_x(alu_x), .alu_y(alu_y), .alu_instr(alu_instr),
    .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng), .halted(halted)
  );
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  logic [15:0] rom [0:32767];
  bit valid [0:32767];
  logic [14:0] exp_f [$];
  logic [31:0] exp_d [$];
  int idly = 0, ddly = 0, icnt = 0, dcnt = 0, dcyc = 0;
  bit ihold = 0, iforce = 0;
  logic [15:0] rdval = 0, last_y = 0;
  logic [8:0] last_ai = 0;
  logic [15:0] x1, y1, fr, sh;
  always_comb begin
    x1 = alu_instr[5] ? 16'h0 : alu_x;
    x1 = alu_instr[4] ? ~x1 : x1;
    y1 = alu_instr[3] ? 16'h0 : alu_y;
    y1 = alu_instr[2] ? ~y1 : y1;
    fr = alu_instr[1] ? x1 + y1 : x1 & y1;
    fr = alu_instr[0] ? ~fr : fr;
    sh = alu_instr[5:4] == 2'b11 ? alu_x << 1 : alu_instr[5:4] == 2'b10 ? alu_x >> 1 :
         alu_instr[5:4] == 2'b01 ? alu_y << 1 : alu_y >> 1;
    alu_out = alu_instr[8] ? fr : sh;
    alu_zr = alu_out == 16'h0;
    alu_ng = alu_out[15];
  end
  logic ireq_p = 0, dreq_p = 0;
  logic [14:0] iaddr_p;
  logic [31:0] dsig_p;
  always @(negedge clk) begin
    logic [14:0] e;
    if (alu_instr != 9'h0) begin
      last_ai = alu_instr;
      last_y = alu_y;
    end
    if (instr_req === 1'b1 && ireq_p && instr_addr !== iaddr_p) begin
      tests++; fails++;
      $display("FAIL instr_addr_stable got %h want %h", instr_addr, iaddr_p);
    end
    ireq_p = instr_req === 1'b1;
    iaddr_p = instr_addr;
    if (!iforce) begin
      instr_ack = 0;
      if (instr_req === 1'b1 && !ihold && valid[instr_addr]) begin
        if (icnt == idly) begin
          instr_ack = 1;
          instr_data = rom[instr_addr];
          icnt = 0;
          if (exp_f.size() > 0) begin
            e = exp_f.pop_front();
            tests++;
            if (instr_addr !== e) begin
              fails++;
              $display("FAIL fetch_addr got %h want %h", instr_addr, e);
            end
          end
        end else icnt++;
      end else icnt = 0;
    end
  end
  always @(negedge clk) begin
    logic [31:0] e, s;
    s = {data_we, data_addr, data_wdata};
    if (data_req === 1'b1) dcyc++;
    if (data_req === 1'b1 && dreq_p && s !== dsig_p) begin
      tests++; fails++;
      $display("FAIL data_stable got %h want %h", s, dsig_p);
    end
    dreq_p = data_req === 1'b1;
    dsig_p = s;
    data_ack = 0;
    if (data_req === 1'b1) begin
      if (dcnt == ddly) begin
        data_ack = 1;
        data_rdata = rdval;
        dcnt = 0;
        tests++;
        if (exp_d.size() == 0) begin
          fails++;
          $display("FAIL data_unexpected got %h want none", s);
        end else begin
          e = exp_d.pop_front();
          if (e[31] ? s !== e : s[31:16] !== e[31:16]) begin
            fails++;
            $display("FAIL data_xfer got %h want %h", s, e);
          end
        end
      end else dcnt++;
    end else dcnt = 0;
  end
  task do_reset;
    @(negedge clk);
    reset = 1;
    ihold = 0; iforce = 0; idly = 0; ddly = 0;
    exp_f.delete(); exp_d.delete();
    for (int i = 0; i < 32768; i++) valid[i] = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    dcyc = 0; last_ai = 0;
  endtask
  task load(input logic [14:0] ad, input logic [15:0] w);
    rom[ad] = w;
    valid[ad] = 1;
  endtask
  task wait_stall(output bit ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (instr_req === 1'b1 && !valid[instr_addr]) begin
        ok = 1;
        break;
      end
    end
  endtask
  task test_reset;
    @(negedge clk);
    reset = 1;
    repeat (2) @(negedge clk);
    tests++;
    if ({instr_req, data_req, data_we, halted} !== 4'b0 || instr_addr !== 15'h0) begin
      fails++;
      $display("FAIL reset_ctrl got %b/%h want 0000/0000", {instr_req, data_req, data_we, halted}, instr_addr);
    end
    tests++;
    if ({alu_x, alu_y, alu_instr} !== 41'h0) begin
      fails++;
      $display("FAIL reset_alu got %h/%h/%h want 0", alu_x, alu_y, alu_instr);
    end
  endtask
  task test_a_then_c;
    bit ok;
    do_reset();
    load(0, 16'h0005); load(1, 16'hEC10);
    exp_f.push_back(0); exp_f.push_back(1);
    wait_stall(ok);
    tests++;
    if (!ok || instr_addr !== 15'd2 || alu_x !== 16'd5 || exp_f.size() != 0) begin
      fails++;
      $display("FAIL basic got ok=%0d pc=%h d=%h q=%0d want pc=0002 d=0005", ok, instr_addr, alu_x, exp_f.size());
    end
    tests++;
    if (last_ai !== 9'h1B0 || alu_instr !== 9'h0) begin
      fails++;
      $display("FAIL basic_alu_instr got %h/%h want 1b0/000", last_ai, alu_instr);
    end
  endtask
  task test_shift;
    bit ok;
    do_reset();
    load(0, 16'h0005); load(1, 16'hEC10); load(2, 16'h8C10);
    exp_f.push_back(0); exp_f.push_back(1); exp_f.push_back(2);
    wait_stall(ok);
    tests++;
    if (!ok || instr_addr !== 15'd3 || alu_x !== 16'd10 || last_ai !== 9'h030) begin
      fails++;
      $display("FAIL shl got pc=%h d=%h ai=%h want 0003/000a/030", instr_addr, alu_x, last_ai);
    end
    exp_f.push_back(3);
    load(3, 16'h8010);
    wait_stall(ok);
    tests++;
    if (!ok || instr_addr !== 15'd4 || alu_x !== 16'd2 || exp_f.size() != 0) begin
      fails++;
      $display("FAIL shr got pc=%h d=%h want 0004/0002", instr_addr, alu_x);
    end
  endtask
  task test_write;
    bit ok;
    do_reset();
    ddly = 3;
    load(0, 16'h0007); load(1, 16'hEC10); load(2, 16'h0064); load(3, 16'hE308);
    for (int i = 0; i < 4; i++) exp_f.push_back(15'(i));
    exp_d.push_back({1'b1, 15'd100, 16'd7});
    wait_stall(ok);
    tests++;
    if (!ok || instr_addr !== 15'd4 || exp_d.size() != 0 || dcyc != 4) begin
      fails++;
      $display("FAIL write got pc=%h q=%0d cycles=%0d want 0004/0/4", instr_addr, exp_d.size(), dcyc);
    end
  endtask
  task test_read;
    bit ok;
    do_reset();
    rdval = 16'h1234;
    load(0, 16'h0064); load(1, 16'hFC10);
    exp_f.push_back(0); exp_f.push_back(1);
    exp_d.push_back({1'b0, 15'd100, 16'h0});
    wait_stall(ok);
    tests++;
    if (!ok || instr_addr !== 15'd2 || alu_x !== 16'h1234 || last_y !== 16'h1234 || exp_d.size() != 0) begin
      fails++;
      $display("FAIL read got pc=%h d=%h y=%h want 0002/1234/1234", instr_addr, alu_x, last_y);
    end
  endtask
  task test_old_a;
    bit ok;
    do_reset();
    load(0, 16'h0032); load(1, 16'hEDE8); load(2, 16'hEC10);
    for (int i = 0; i < 3; i++) exp_f.push_back(15'(i));
    exp_d.push_back({1'b1, 15'd50, 16'd51});
    wait_stall(ok);
    tests++;
    if (!ok || instr_addr !== 15'd3 || alu_x !== 16'd51 || exp_d.size() != 0) begin
      fails++;
      $display("FAIL am_write got pc=%h d=%h q=%0d want 0003/0033/0", instr_addr, alu_x, exp_d.size());
    end
  endtask
  task test_jumps;
    bit ok;
    do_reset();
    load(0, 16'h0007); load(1, 16'hEA87);
    exp_f.push_back(0); exp_f.push_back(1);
    wait_stall(ok);
    tests++;
    if (!ok || instr_addr !== 15'd7 || halted !== 1'b0) begin
      fails++;
      $display("FAIL jmp got pc=%h h=%b want 0007/0", instr_addr, halted);
    end
    do_reset();
    load(0, 16'hEE90); load(1, 16'h0014); load(2, 16'hE304);
    for (int i = 0; i < 3; i++) exp_f.push_back(15'(i));
    wait_stall(ok);
    tests++;
    if (!ok || instr_addr !== 15'd20 || alu_x !== 16'hFFFF) begin
      fails++;
      $display("FAIL jlt_taken got pc=%h d=%h want 0014/ffff", instr_addr, alu_x);
    end
    do_reset();
    load(0, 16'hEFD0); load(1, 16'h0014); load(2, 16'hE304);
    for (int i = 0; i < 3; i++) exp_f.push_back(15'(i));
    wait_stall(ok);
    tests++;
    if (!ok || instr_addr !== 15'd3 || alu_x !== 16'h0001 || exp_f.size() != 0) begin
      fails++;
      $display("FAIL jlt_fall got pc=%h d=%h want 0003/0001", instr_addr, alu_x);
    end
  endtask
  task test_wrap;
    bit ok;
    do_reset();
    load(0, 16'h7FFF); load(1, 16'hEA87); load(15'h7FFF, 16'hEC10);
    exp_f.push_back(0); exp_f.push_back(1); exp_f.push_back(15'h7FFF);
    for (int i = 0; i < 300 && exp_f.size() != 0; i++) @(negedge clk);
    valid[0] = 0;
    wait_stall(ok);
    tests++;
    if (!ok || instr_addr !== 15'h0 || alu_x !== 16'h7FFF || exp_f.size() != 0) begin
      fails++;
      $display("FAIL pc_wrap got pc=%h d=%h want 0000/7fff", instr_addr, alu_x);
    end
  endtask
  task test_reset_mid_and_loop;
    bit bad;
    do_reset();
    load(0, 16'hEFD0);
    ihold = 1;
    repeat (3) @(negedge clk);
    reset = 1; iforce = 1; instr_ack = 1; instr_data = 16'hFFFF;
    @(negedge clk);
    tests++;
    if (instr_req !== 1'b0 || data_req !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_req got %b%b want 00", instr_req, data_req);
    end
    reset = 0;
    @(negedge clk);
    load(0, 16'h0002); load(1, 16'hEA87); load(2, 16'h0002); load(3, 16'hEA87);
    for (int i = 0; i < 4; i++) exp_f.push_back(15'(i));
    tests++;
    if (instr_req !== 1'b1 || instr_addr !== 15'h0 || alu_x !== 16'h0) begin
      fails++;
      $display("FAIL restart got req=%b pc=%h d=%h want 1/0000/0000", instr_req, instr_addr, alu_x);
    end
    ihold = 0; icnt = 0; instr_ack = 0; iforce = 0;
`ifdef HALT_LOOP_EN
    for (int i = 0; i < 300 && halted !== 1'b1; i++) @(negedge clk);
    tests++;
    if (halted !== 1'b1 || exp_f.size() != 0) begin
      fails++;
      $display("FAIL halt got h=%b q=%0d want 1/0", halted, exp_f.size());
    end
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (instr_req !== 1'b0 || data_req !== 1'b0 || halted !== 1'b1) bad = 1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL halt_quiet got activity want none");
    end
`else
    for (int i = 0; i < 3; i++) begin
      exp_f.push_back(2);
      exp_f.push_back(3);
    end
    bad = 0;
    for (int i = 0; i < 300 && exp_f.size() != 0; i++) begin
      @(negedge clk);
      if (halted !== 1'b0) bad = 1;
    end
    tests++;
    if (bad || exp_f.size() != 0) begin
      fails++;
      $display("FAIL loop got q=%0d h_seen=%0d want 0/0", exp_f.size(), bad);
    end
`endif
  endtask
  initial begin
    test_reset();
    test_a_then_c();
    test_shift();
    test_write();
    test_read();
    test_old_a();
    test_jumps();
    test_wrap();
    test_reset_mid_and_loop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
